// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two independent lanes, each taking a raw active-low push
//                button through a two-flop synchronizer and a stable-count
//                debouncer, then a hold-to-repeat FSM that periodically drops
//                the output for a short gap while the button stays held.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE      = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int GAP           = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] nButton,
  output logic [1:0] Button
);

  // Debounce counter only has to reach DEBOUNCE-1.
  localparam int c_DB_W = $clog2(DEBOUNCE);
  // Repeat timer must reach the larger of the hold delay and the ON phase.
  localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_RC_W = $clog2(c_RMAX + 1);

  localparam logic [c_DB_W-1:0] c_DB_LAST    = c_DB_W'(DEBOUNCE - 1);
  localparam logic [c_RC_W-1:0] c_DELAY_LAST = c_RC_W'(REPEAT_DELAY - 1);
  localparam logic [c_RC_W-1:0] c_GAP_LAST   = c_RC_W'(GAP - 1);
  localparam logic [c_RC_W-1:0] c_ON_LAST    = c_RC_W'(REPEAT_PERIOD - GAP - 1);
  localparam logic              c_REP_EN     = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_GAP  = 2'd2,
    ST_ON   = 2'd3
  } state_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;
    logic [c_DB_W-1:0] r_cnt;
    logic [c_RC_W-1:0] r_rcnt;
    state_t            r_state;
    logic              r_btn;
    logic              w_s;

    // Active-high view of the synchronized button.
    assign w_s = ~r_sync2;

    // Two-flop synchronizer; reset value is "released" so a held button
    // after reset is seen as a fresh press.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= nButton[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Accept a new level only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else if (w_s == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_stable <= w_s;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Repeat FSM with registered output; a release always wins over timer expiry.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
        r_btn   <= 1'b0;
      end else if (!r_stable) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
        r_btn   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_HELD;
            r_rcnt  <= '0;
            r_btn   <= 1'b1;
          end
          ST_HELD: begin
            if (c_REP_EN && (r_rcnt == c_DELAY_LAST)) begin
              r_state <= ST_GAP;
              r_rcnt  <= '0;
              r_btn   <= 1'b0;
            end else begin
              // Without repeat the timer is parked so it never wraps.
              r_rcnt <= c_REP_EN ? (r_rcnt + 1'b1) : '0;
              r_btn  <= 1'b1;
            end
          end
          ST_GAP: begin
            if (r_rcnt == c_GAP_LAST) begin
              r_state <= ST_ON;
              r_rcnt  <= '0;
              r_btn   <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
              r_btn  <= 1'b0;
            end
          end
          ST_ON: begin
            if (r_rcnt == c_ON_LAST) begin
              r_state <= ST_GAP;
              r_rcnt  <= '0;
              r_btn   <= 1'b0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
              r_btn  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
            r_btn   <= 1'b0;
          end
        endcase
      end
    end

    assign Button[gi] = r_btn;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Directed bench for button_debounce. A repeat-enabled and a
//                repeat-disabled instance share the same inputs; both are
//                compared every cycle against a behavioural model, and key
//                latencies and gap patterns are pinned with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int DEB  = 8;
  localparam int DLY  = 40;
  localparam int PER  = 20;
  localparam int GAPN = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] n_btn = 2'b11;
  logic [1:0] btn_r;
  logic [1:0] btn_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE(DEB), .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .GAP(GAPN)
  ) u_dut_rep (
    .Clk(clk), .Reset(rst), .nButton(n_btn), .Button(btn_r)
  );

  button_debounce #(
    .DEBOUNCE(DEB), .REPEAT_EN(0), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .GAP(GAPN)
  ) u_dut_norep (
    .Clk(clk), .Reset(rst), .nButton(n_btn), .Button(btn_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output level of a held button, given edges elapsed since it first went high.
  function automatic logic rep_level(input int hold);
    if (hold < DLY) return 1'b1;
    return (((hold - DLY) % PER) >= GAPN);
  endfunction

  logic       m_raw1[2];   // raw level seen one edge ago
  logic       m_raw2[2];   // raw level seen two edges ago
  logic       m_stable[2];
  int         m_run[2];    // consecutive samples disagreeing with m_stable
  logic       m_act[2];
  int         m_hold[2];
  logic [1:0] m_out_rep   = 2'b00;
  logic [1:0] m_out_norep = 2'b00;
  bit         m_live      = 1'b0;

  always @(posedge clk) begin : p_model
    logic s;
    m_live = 1'b1;
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        m_raw1[l] = 1'b1; m_raw2[l] = 1'b1; m_stable[l] = 1'b0; m_run[l] = 0;
        m_act[l] = 1'b0; m_hold[l] = 0; m_out_rep[l] = 1'b0; m_out_norep[l] = 1'b0;
      end else begin
        s = !m_raw2[l];
        if (!m_stable[l]) begin
          m_act[l] = 1'b0; m_hold[l] = 0;
          m_out_rep[l] = 1'b0; m_out_norep[l] = 1'b0;
        end else begin
          if (m_act[l]) m_hold[l]++;
          else begin m_act[l] = 1'b1; m_hold[l] = 0; end
          m_out_rep[l]   = rep_level(m_hold[l]);
          m_out_norep[l] = 1'b1;
        end
        if (s == m_stable[l]) m_run[l] = 0;
        else begin
          m_run[l]++;
          if (m_run[l] == DEB) begin m_stable[l] = s; m_run[l] = 0; end
        end
        m_raw2[l] = m_raw1[l];
        m_raw1[l] = n_btn[l];
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_rep", 32'(btn_r), 32'(m_out_rep));
      chk("cmp_norep", 32'(btn_n), 32'(m_out_norep));
    end
  end

  // Edges until the selected output reaches lvl; -1 if the bound expires.
  task automatic wait_level(input int b, input int lane, input logic lvl, input int limit,
                            output int k);
    logic v;
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      v = (b == 0) ? btn_r[lane] : btn_n[lane];
      if (v == lvl) begin k = i; break; end
    end
  endtask

  // Press a lane, check the 11-edge rise and 40-edge first high phase.
  task automatic press_width(input int lane, input string tag);
    int k;
    @(negedge clk); n_btn[lane] = 1'b0;
    wait_level(0, lane, 1'b1, 30, k);
    chk({tag, "_rise"}, k, 11);
    wait_level(0, lane, 1'b0, 80, k);
    chk({tag, "_delay"}, k, 40);
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : p_stim
    int k, r0, r1, lows, nf, nr, mnf, rises_seen;
    int falls[8];
    int rises[8];
    logic pv, mpv;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(btn_r), 0);
    chk("reset_out_norep", 32'(btn_n), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_out", 32'(btn_r), 0);

    // Clean press / release on lane 0
    n_btn[0] = 1'b0;
    wait_level(0, 0, 1'b1, 30, k);
    chk("press_latency", k, 11);
    chk("down_stays_low", 32'(btn_r[1]), 0);
    @(negedge clk); n_btn[0] = 1'b1;
    wait_level(0, 0, 1'b0, 30, k);
    chk("release_latency", k, 11);

    // Bounce rejection: 7 low / 1 high, five times
    @(negedge clk);
    repeat (5) begin
      n_btn[0] = 1'b0;
      repeat (7) @(negedge clk);
      n_btn[0] = 1'b1;
      @(negedge clk);
    end
    chk("bounce_reject", 32'(btn_r), 0);
    n_btn[0] = 1'b0;
    wait_level(0, 0, 1'b1, 30, k);
    chk("bounce_then_hold", k, 11);
    @(negedge clk); n_btn[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Hold-to-repeat on lane 1 for 140 edges
    for (int i = 0; i < 8; i++) begin falls[i] = 0; rises[i] = 0; end
    n_btn[1] = 1'b0; pv = 1'b0; mpv = 1'b0; nf = 0; nr = 0; mnf = 0;
    for (int e = 1; e <= 140; e++) begin
      @(posedge clk); #1;
      if (btn_r[1] && !pv) begin if (nr < 8) rises[nr] = e; nr++; end
      if (!btn_r[1] && pv) begin if (nf < 8) falls[nf] = e; nf++; end
      if (!m_out_rep[1] && mpv) mnf++;
      pv = btn_r[1]; mpv = m_out_rep[1];
    end
    chk("hold_rise", rises[0], 11);
    chk("hold_first_high", falls[0] - rises[0], 40);
    chk("hold_gap_len", rises[1] - falls[0], 4);
    chk("hold_on_len", falls[1] - rises[1], 16);
    chk("hold_gap_count", nf, 5);
    chk("model_gap_count", mnf, 5);
    @(negedge clk); n_btn[1] = 1'b1;
    wait_level(0, 1, 1'b0, 30, k);
    chk("hold_release", k, 11);
    repeat (5) @(negedge clk);

    // Release timed so the debounced fall lands inside a GAP
    n_btn[0] = 1'b0;
    repeat (42) @(negedge clk);
    n_btn[0] = 1'b1;
    pv = 1'b1; rises_seen = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (btn_r[0] && !pv) rises_seen++;
      pv = btn_r[0];
    end
    chk("gap_release_no_rise", rises_seen, 0);
    chk("gap_release_low", 32'(btn_r[0]), 0);
    repeat (3) @(negedge clk);
    press_width(0, "after_gap");

    // Release during ON: output returns high after the gap, then drops
    @(negedge clk); n_btn[0] = 1'b1;
    wait_level(0, 0, 1'b1, 10, k);
    chk("on_release_regain", k, 4);
    wait_level(0, 0, 1'b0, 20, k);
    chk("on_release_fall", k, 7);
    repeat (5) @(negedge clk);
    press_width(0, "after_on");
    @(negedge clk); n_btn[0] = 1'b1;
    repeat (20) @(negedge clk);

    // Both buttons, staggered by 3, then a 1-cycle reset mid-hold
    n_btn[0] = 1'b0; r0 = 0; r1 = 0;
    for (int e = 1; e <= 25; e++) begin
      if (e == 4) n_btn[1] = 1'b0;
      @(posedge clk); #1;
      if (btn_r[0] && r0 == 0) r0 = e;
      if (btn_r[1] && r1 == 0) r1 = e;
      @(negedge clk);
    end
    chk("both_rise0", r0, 11);
    chk("both_stagger", r1 - r0, 3);
    chk("both_high", 32'(btn_r), 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_drop", 32'(btn_r), 0);
    @(negedge clk); rst = 1'b0;
    r0 = 0; r1 = 0;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (btn_r[0] && r0 == 0) r0 = e;
      if (btn_r[1] && r1 == 0) r1 = e;
    end
    chk("rerise0", r0, 11);
    chk("rerise1", r1, 11);
    @(negedge clk); n_btn = 2'b11;
    repeat (20) @(negedge clk);

    // Repeat-disabled instance: long hold without gaps
    n_btn[0] = 1'b0; r0 = 0; lows = 0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (btn_n[0] && r0 == 0) r0 = e;
      else if (r0 != 0 && !btn_n[0]) lows++;
    end
    chk("norep_rise", r0, 11);
    chk("norep_no_gaps", lows, 0);
    @(negedge clk); n_btn[0] = 1'b1;
    wait_level(1, 0, 1'b0, 30, k);
    chk("norep_release", k, 11);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
